rally_match_ctrl: RTL and testbench
===================================

# rally_match_ctrl

Parametrised two-player rally controller for the tennis/squash simulation. It integrates the ball mover and the match scorer in one block. It drives an N-LED ball track, detects hits, misses and early presses, and keeps per-player scores, serve ownership and match state. It sits between the debounced player buttons and the LED/score display logic, and replaces the fixed 16-LED, 2-bit-score player logic.

## Interface
- N_LEDS, 16: track length; bit 0 is the right player's end, bit N_LEDS-1 the left player's end (≥4).
- STEP_DIV, 25_000_000: clock cycles per ball step (≥2).
- SCORE_W, 4: score counter width.
- POINTS_TO_WIN, 3: points needed to win; must satisfy POINTS_TO_WIN+1 ≤ 2^SCORE_W-1.
- MAX_PENALTY, 2: early presses in one point that forfeit the point (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- left_btn  in  1  left player button, already synchronised and debounced (level).
- right_btn  in  1  right player button, already synchronised and debounced (level).
- light  out  N_LEDS  one-hot ball position.
- left_score  out  SCORE_W  left player points.
- right_score  out  SCORE_W  right player points.
- server  out  1  0 = right serves, 1 = left serves.
- in_game  out  1  match in progress.
- point_pulse  out  1  one-cycle strobe on every point award.
- winner  out  2  00 none, 01 right won, 10 left won.

## Operation
- Buttons are edge-detected against a registered copy. Only rising edges act.
- Ball position `pos` is in 0..N_LEDS-1. `light` = 1<<pos.
- Tick counter runs 0..STEP_DIV-1 and pulses at STEP_DIV-1. It clears on launch and on every hit.
- States: SERVE, FLY_L (pos increasing), FLY_R (pos decreasing), OVER.
- SERVE: the ball is parked at the server's end (pos 0 for right, N_LEDS-1 for left).
  - A server edge launches the ball toward the opponent: FLY_L if right serves, FLY_R if left serves. Launch sets in_game=1.
  - If in_game was 0 when launched, both scores and `winner` clear.
  - Non-server edges are ignored.
- FLY_L / FLY_R, receiver = the player the ball moves toward:
  - A tick while not at the receiver's end steps pos by one.
  - A receiver edge while pos equals the receiver's end is a hit. Direction reverses, the tick counter clears, and pos stays for this cycle.
  - A tick while pos is at the receiver's end with no hit is a miss. The point goes to the opponent.
  - A receiver edge while pos is not at the end is an early press and increments the receiver's penalty counter. When it reaches MAX_PENALTY, the point goes to the opponent.
  - Edges from the non-receiver are ignored.
- Point award:
  - The scorer's score increments, saturating at 2^SCORE_W-1.
  - point_pulse fires and both penalty counters clear.
  - `server` toggles and the ball parks at the new server's end. Next state is SERVE.
  - If the win condition is met: `winner` is set, in_game=0, server is set to the loser, the ball parks at the loser's end, and next state is OVER.
- OVER: scores and `winner` are held. A server (loser) edge behaves as a launch from SERVE with in_game=0.
- Simultaneous events:
  - A hit and a tick in the same cycle: the hit wins.
  - Both buttons rise together: only the edge relevant to the current state is acted on.
  - Classification always uses the registered pos before the update. A press in the cycle the ball steps onto the end therefore counts as early.

## Timing
- All outputs are registered. Effects of an edge or tick detected at clock edge k are visible after edge k.
- After launch, the first step occurs STEP_DIV cycles later. A full traverse takes (N_LEDS-1)·STEP_DIV cycles, plus a one-tick hit window at the far end.
- point_pulse is high for exactly one cycle per award.
- Reset values: light=1, left_score=0, right_score=0, server=0, in_game=0, point_pulse=0, winner=00. State is SERVE, with penalties and tick counter at 0.
- Reset asserted mid-rally forces the reset values asynchronously, without a clock.

## Configuration
- RALLY_WIN_BY_TWO_EN undefined: a player wins when their score equals POINTS_TO_WIN.
- RALLY_WIN_BY_TWO_EN defined:
  - A player wins when their score is ≥ POINTS_TO_WIN and they lead by ≥2.
  - After any award that leaves the scores tied at ≥ POINTS_TO_WIN, both are set to POINTS_TO_WIN-1 (deuce), so scores stay bounded.

## Test plan
Bench parameters: N_LEDS=8, STEP_DIV=4, POINTS_TO_WIN=3, MAX_PENALTY=2.

- Reset: light=8'h01, scores 0, server=0, in_game=0, winner=00. Right edge → in_game=1; light=8'h02 four cycles later; light=8'h80 after 28 cycles.
- Rally: left edge while light=8'h80 → FLY_R, light=8'h40 four cycles later. Then no right press while light=8'h01 until the tick → left_score=1, one-cycle point_pulse, server=1, light=8'h80.
- Penalty: two separate left edges while light=8'h08 in FLY_L → right_score+1 on the second edge, penalties cleared, server toggled.
- Match win (macro off): right takes 3 points → winner=01, in_game=0, server=1, light=8'h80. Right edges are ignored. A left edge clears scores and winner and launches FLY_R.
- Macro on: from 2-2, left scores (no win). Right scores → tied 3-3 collapses to 2-2. Right scores twice more → 4-2, winner=01. Macro off, same sequence: the first 3-2 ends the match.
- Async reset asserted mid-FLY_L between clock edges → all outputs take their reset values immediately.

Source files
------------

// File: rtl/rally_match_ctrl.sv
// Two-player rally controller: moves the ball along an N-LED track, classifies hits, misses and
// early presses, and keeps the match score. Define RALLY_WIN_BY_TWO_EN for win-by-two with deuce.
module rally_match_ctrl #(
    parameter int N_LEDS        = 16,
    parameter int STEP_DIV      = 25_000_000,
    parameter int SCORE_W       = 4,
    parameter int POINTS_TO_WIN = 3,
    parameter int MAX_PENALTY   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               left_btn,
    input  logic               right_btn,
    output logic [N_LEDS-1:0]  light,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               server,
    output logic               in_game,
    output logic               point_pulse,
    output logic [1:0]         winner
);
    localparam int POS_W  = $clog2(N_LEDS);
    localparam int TICK_W = $clog2(STEP_DIV);
    localparam int PEN_W  = $clog2(MAX_PENALTY + 1);

    localparam logic [POS_W-1:0]   LEFT_END  = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]   RIGHT_END = '0;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(STEP_DIV - 1);
    localparam logic [PEN_W-1:0]   PEN_LIMIT = PEN_W'(MAX_PENALTY);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(POINTS_TO_WIN);
    localparam logic [N_LEDS-1:0]  LIGHT_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {SERVE, FLY_L, FLY_R, OVER} state_t;

    state_t             state, state_d;
    logic [POS_W-1:0]   pos, pos_d;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_d;
    logic [PEN_W-1:0]   left_pen, left_pen_d, right_pen, right_pen_d;
    logic               left_prev, right_prev;
    logic [SCORE_W-1:0] left_score_d, right_score_d;
    logic               server_d, in_game_d, point_pulse_d;
    logic [1:0]         winner_d;
    logic               left_rise, right_rise, tick;
    logic               award, award_left, win;
    logic [SCORE_W-1:0] won_score;

    assign left_rise  = left_btn & ~left_prev;
    assign right_rise = right_btn & ~right_prev;
    assign tick       = (tick_cnt == TICK_LAST);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    always_comb begin
        state_d       = state;
        pos_d         = pos;
        tick_cnt_d    = tick ? '0 : tick_cnt + TICK_W'(1);
        left_pen_d    = left_pen;
        right_pen_d   = right_pen;
        left_score_d  = left_score;
        right_score_d = right_score;
        server_d      = server;
        in_game_d     = in_game;
        point_pulse_d = 1'b0;
        winner_d      = winner;
        award         = 1'b0;
        award_left    = 1'b0;
        win           = 1'b0;
        won_score     = '0;

        case (state)
            SERVE, OVER: begin
                if (server ? left_rise : right_rise) begin
                    state_d    = server ? FLY_R : FLY_L;
                    in_game_d  = 1'b1;
                    tick_cnt_d = '0;
                    if (!in_game) begin
                        left_score_d  = '0;
                        right_score_d = '0;
                        winner_d      = 2'b00;
                    end
                end
            end
            FLY_L: begin
                // Left is receiving; a hit has priority over the tick that would be a miss.
                if (left_rise && pos == LEFT_END) begin
                    state_d    = FLY_R;
                    tick_cnt_d = '0;
                end else if (tick && pos == LEFT_END) begin
                    award = 1'b1;
                end else begin
                    if (tick) pos_d = pos + POS_W'(1);
                    if (left_rise) begin
                        left_pen_d = left_pen + PEN_W'(1);
                        if (left_pen_d == PEN_LIMIT) award = 1'b1;
                    end
                end
            end
            FLY_R: begin
                if (right_rise && pos == RIGHT_END) begin
                    state_d    = FLY_L;
                    tick_cnt_d = '0;
                end else if (tick && pos == RIGHT_END) begin
                    award      = 1'b1;
                    award_left = 1'b1;
                end else begin
                    if (tick) pos_d = pos - POS_W'(1);
                    if (right_rise) begin
                        right_pen_d = right_pen + PEN_W'(1);
                        if (right_pen_d == PEN_LIMIT) begin
                            award      = 1'b1;
                            award_left = 1'b1;
                        end
                    end
                end
            end
            default: state_d = SERVE;
        endcase

        if (award) begin
            if (award_left) left_score_d = sat_inc(left_score);
            else            right_score_d = sat_inc(right_score);
            point_pulse_d = 1'b1;
            left_pen_d    = '0;
            right_pen_d   = '0;
            won_score     = award_left ? left_score_d : right_score_d;
`ifdef RALLY_WIN_BY_TWO_EN
            win = (won_score >= WIN_PTS) &&
                  ({1'b0, won_score} >= {1'b0, (award_left ? right_score_d : left_score_d)} + (SCORE_W+1)'(2));
`else
            win = (won_score == WIN_PTS);
`endif
            if (win) begin
                // The loser serves the next match from their own end.
                winner_d  = award_left ? 2'b10 : 2'b01;
                in_game_d = 1'b0;
                server_d  = ~award_left;
                state_d   = OVER;
            end else begin
`ifdef RALLY_WIN_BY_TWO_EN
                if (left_score_d == right_score_d && left_score_d >= WIN_PTS) begin
                    left_score_d  = WIN_PTS - SCORE_W'(1);
                    right_score_d = WIN_PTS - SCORE_W'(1);
                end
`endif
                server_d = ~server;
                state_d  = SERVE;
            end
            pos_d = server_d ? LEFT_END : RIGHT_END;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SERVE;
            pos         <= RIGHT_END;
            tick_cnt    <= '0;
            left_pen    <= '0;
            right_pen   <= '0;
            left_prev   <= 1'b0;
            right_prev  <= 1'b0;
            light       <= LIGHT_ONE;
            left_score  <= '0;
            right_score <= '0;
            server      <= 1'b0;
            in_game     <= 1'b0;
            point_pulse <= 1'b0;
            winner      <= 2'b00;
        end else begin
            state       <= state_d;
            pos         <= pos_d;
            tick_cnt    <= tick_cnt_d;
            left_pen    <= left_pen_d;
            right_pen   <= right_pen_d;
            left_prev   <= left_btn;
            right_prev  <= right_btn;
            light       <= LIGHT_ONE << pos_d;
            left_score  <= left_score_d;
            right_score <= right_score_d;
            server      <= server_d;
            in_game     <= in_game_d;
            point_pulse <= point_pulse_d;
            winner      <= winner_d;
        end
    end
endmodule

// File: tb/tb_rally_match_ctrl.sv
// Bench for rally_match_ctrl: randomized rallies checked against a point-level match model.
module tb_rally_match_ctrl;
    localparam int N  = 8;
    localparam int SD = 4;
    localparam int SW = 4;
    localparam int P  = 3;
    localparam int MP = 2;
    localparam int SAT = (1 << SW) - 1;
    localparam int M_HIT = 0, M_MISS = 1, M_EARLY = 2, M_ONE_EARLY = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          left_btn = 1'b0;
    logic          right_btn = 1'b0;
    logic [N-1:0]  light;
    logic [SW-1:0] left_score, right_score;
    logic          server, in_game, point_pulse;
    logic [1:0]    winner;

    rally_match_ctrl #(
        .N_LEDS(N), .STEP_DIV(SD), .SCORE_W(SW), .POINTS_TO_WIN(P), .MAX_PENALTY(MP)
    ) dut (
        .clock(clock), .reset(reset), .left_btn(left_btn), .right_btn(right_btn),
        .light(light), .left_score(left_score), .right_score(right_score),
        .server(server), .in_game(in_game), .point_pulse(point_pulse), .winner(winner)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int m_ls, m_rs, m_pos, m_server, m_in_game, m_winner, m_pulse;

    task automatic model_reset();
        m_ls = 0; m_rs = 0; m_pos = 0; m_server = 0;
        m_in_game = 0; m_winner = 0; m_pulse = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] exp_light;
        exp_light = {{(N-1){1'b0}}, 1'b1} << m_pos;
        check({tag, ".light"},  32'(light),       32'(exp_light));
        check({tag, ".lscore"}, 32'(left_score),  32'(m_ls));
        check({tag, ".rscore"}, 32'(right_score), 32'(m_rs));
        check({tag, ".server"}, 32'(server),      32'(m_server));
        check({tag, ".ingame"}, 32'(in_game),     32'(m_in_game));
        check({tag, ".pulse"},  32'(point_pulse), 32'(m_pulse));
        check({tag, ".winner"}, 32'(winner),      32'(m_winner));
    endtask

    // Drive button levels for the next rising edge and return at the following falling edge.
    task automatic clk_cycle(input logic lb, input logic rb);
        left_btn  = lb;
        right_btn = rb;
        @(negedge clock);
    endtask

    task automatic award(input int left_scores);
        int  s;
        bit  won;
        if (left_scores != 0) m_ls = (m_ls == SAT) ? SAT : m_ls + 1;
        else                  m_rs = (m_rs == SAT) ? SAT : m_rs + 1;
        s = (left_scores != 0) ? m_ls : m_rs;
`ifdef RALLY_WIN_BY_TWO_EN
        won = (s >= P) && (s - ((left_scores != 0) ? m_rs : m_ls) >= 2);
`else
        won = (s == P);
`endif
        m_pulse = 1;
        if (won) begin
            m_winner  = (left_scores != 0) ? 2 : 1;
            m_in_game = 0;
            m_server  = (left_scores != 0) ? 0 : 1;
        end else begin
`ifdef RALLY_WIN_BY_TWO_EN
            if (m_ls == m_rs && m_ls >= P) begin
                m_ls = P - 1;
                m_rs = P - 1;
            end
`endif
            m_server = 1 - m_server;
        end
        m_pos = (m_server != 0) ? N - 1 : 0;
    endtask

    function automatic int steps_of(input int j);
        return (j / SD > N - 1) ? N - 1 : j / SD;
    endfunction

    // One flight of the ball, j counts edges since the launch or hit that started it.
    task automatic leg(input int inc, input int mode, input int stop_j, input string tag);
        int   hit_j, pens;
        int   early_j [MP];
        logic press, noise;
        hit_j = (N - 1) * SD + 1 + int'($urandom_range(0, SD - 1));
        early_j[0] = 2 + int'($urandom_range(0, 8));
        for (int k = 1; k < MP; k++) early_j[k] = early_j[k-1] + 2 + int'($urandom_range(0, 8));
        if ($urandom_range(0, 1) == 1) early_j[MP-1] = (N - 1) * SD;
        pens = 0;
        for (int j = 1; j <= N * SD; j++) begin
            press = 1'b0;
            if (mode == M_HIT && j == hit_j) press = 1'b1;
            if (mode == M_EARLY && pens < MP && j == early_j[pens]) press = 1'b1;
            if (mode == M_ONE_EARLY && j == early_j[0]) press = 1'b1;
            noise = (j >= 2 && j <= (N - 2) * SD) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_pulse = 0;
            if (inc != 0) clk_cycle(press, noise);
            else          clk_cycle(noise, press);
            m_pos = (inc != 0) ? steps_of(j) : N - 1 - steps_of(j);
            if (press && mode == M_EARLY) pens++;
            if ((mode == M_EARLY && pens == MP) ||
                ((mode == M_MISS || mode == M_ONE_EARLY) && j == N * SD)) begin
                award((inc != 0) ? 0 : 1);
                check_all({tag, ".award"});
                return;
            end
            check_all(tag);
            if (press && mode == M_HIT) return;
            if (j == stop_j) return;
        end
    endtask

    task automatic launch(input string tag);
        logic other;
        other = 1'($urandom_range(0, 1));
        if (m_in_game == 0) begin
            m_ls = 0; m_rs = 0; m_winner = 0;
        end
        m_in_game = 1;
        m_pulse   = 0;
        if (m_server != 0) clk_cycle(1'b1, other);
        else               clk_cycle(other, 1'b1);
        check_all(tag);
    endtask

    // Only the non-server presses here; those must be ignored while parked.
    task automatic idle(input int n, input string tag);
        logic nz;
        for (int j = 0; j < n; j++) begin
            nz = (j == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            m_pulse = 0;
            if (m_server != 0) clk_cycle(1'b0, nz);
            else               clk_cycle(nz, 1'b0);
            check_all(tag);
        end
    endtask

    task automatic play_point(input int left_scores, input int final_mode, input string tag);
        int r, inc;
        r   = int'($urandom_range(0, 2));
        inc = (m_server == 0) ? 1 : 0;
        if ((inc ^ (r % 2)) != ((left_scores == 0) ? 1 : 0)) r++;
        launch({tag, ".launch"});
        for (int k = 0; k < r; k++) begin
            leg(inc, M_HIT, 0, {tag, ".ret"});
            inc = 1 - inc;
        end
        leg(inc, final_mode, 0, {tag, ".final"});
        idle(2 + int'($urandom_range(0, 2)), {tag, ".idle"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clock);
        check_all("reset_hold");
        reset = 1'b0;
        idle(3, "reset_idle");

        play_point(1, M_MISS, "rally");
        play_point(0, M_EARLY, "penalty");
        play_point(1, M_ONE_EARLY, "pen_clear_a");
        play_point(1, M_ONE_EARLY, "pen_clear_b");

        for (int k = 0; k < 3; k++) play_point(0, int'($urandom_range(1, 3)), "right_match");
        idle(4, "over_idle");

        play_point(1, M_MISS, "deuce_l1");
        play_point(0, M_EARLY, "deuce_r1");
        play_point(1, M_ONE_EARLY, "deuce_l2");
        play_point(0, M_MISS, "deuce_r2");
        play_point(1, M_MISS, "deuce_l3");
        play_point(0, M_MISS, "deuce_r3");
        play_point(0, M_EARLY, "deuce_r4");
        play_point(0, M_MISS, "deuce_r5");

        for (int k = 0; k < 8; k++)
            play_point(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), "rand");

        for (int k = 0; k < 4 && m_server != 0; k++)
            play_point(int'($urandom_range(0, 1)), M_MISS, "align");
        launch("pre_rst");
        leg((m_server == 0) ? 1 : 0, M_MISS, 10, "pre_rst_fly");
        #2;
        left_btn  = 1'b0;
        right_btn = 1'b0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        check_all("rst_held");
        reset = 1'b0;
        idle(3, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
